laser_fire_sequencer: RTL
=========================

Name: laser_fire_sequencer

Overview:
- Sequences the player laser datapath: generates its motion-rate `enable` strobe and turns raw fire-button presses into a single-cycle `fire` request.
- The `fire` request is issued only when the laser is dead, and only on an enable cycle.
- Enforces a post-shot cooldown and keeps shot/hit statistics for the score/HUD logic.
- Sits between the input pad/top level and the laser datapath instance.

Parameters:
- MOTION_DIV, 4: clocks per laser enable strobe (>=2).
- COOLDOWN_TICKS, 8: enable strobes to wait after the laser dies before re-arming (0 allowed).
- CNT_W, 8: width of the shot and hit counters.

Ports:
- clk  input  1  system clock.
- reset  input  1  asynchronous, active-high reset.
- gameEnable  input  1  game running; when low, strobes and fire are suppressed.
- fireButton  input  1  raw, asynchronous button level.
- laserActive  input  1  laser-alive status from the datapath.
- killingAlien  input  1  collision flag, same signal the datapath sees.
- laserEnable  output  1  one-cycle motion strobe to the datapath `enable`.
- fire  output  1  one-cycle fire request to the datapath `fire`.
- ready  output  1  high when in IDLE (HUD "gun ready" indicator).
- shotCount  output  CNT_W  shots issued, wraps.
- hitCount  output  CNT_W  hits recorded, wraps.

Behaviour:
- Reset (async, any state):
  - state=IDLE; prescaler=0; cooldown counter=0; synchronizer and edge flops=0.
  - Outputs: laserEnable=0, fire=0, ready=1, shotCount=0, hitCount=0.
- Prescaler:
  - Counts 0..MOTION_DIV-1 while gameEnable=1. laserEnable is registered and is high in the cycle after the count hits MOTION_DIV-1, which gives exactly one strobe per MOTION_DIV clocks.
  - gameEnable=0: prescaler holds its value and laserEnable=0.
- Button input:
  - Two-flop synchronizer, then rising-edge detect.
  - The press pulse is high for 1 cycle, 3 clocks after the button rises.
- fire = (state==ARMED) & laserEnable & ~laserActive, decoded from registered signals only.
- FSM:
  - IDLE: press -> ARMED.
  - ARMED: on a cycle where fire=1 -> FLIGHT, and shotCount+1 on the same edge. If the laser is still active, stay ARMED. Further presses are ignored.
  - FLIGHT: a seenActive flag sets when laserActive=1. Once seenActive=1 and laserActive=0 -> COOLDOWN, load the counter with COOLDOWN_TICKS, clear seenActive. Presses are dropped, not queued.
  - COOLDOWN: the counter decrements on each laserEnable. At 0 -> IDLE. With COOLDOWN_TICKS=0, go to IDLE the cycle after entry. Presses are dropped.
- Hits: hitCount+1 when state==FLIGHT & laserEnable & killingAlien & laserActive, i.e. at most one hit per shot.
- Counters wrap from 2^CNT_W-1 to 0.
- gameEnable falling mid-shot: the state is held; no fire and no strobes. Cooldown counting pauses because no strobes occur.
- Simultaneous press and the ARMED->FLIGHT transition: the press is dropped.

Optional Feature:
- Macro: LASER_AUTOFIRE_EN.
- Defined: in IDLE, a synchronized button level of 1 (held) also triggers ->ARMED. Holding the button therefore fires repeatedly, one shot per laser lifetime plus cooldown.
- Undefined: only a rising edge arms; a held button yields exactly one shot.

Test Plan:
- Reset check: assert reset mid-FLIGHT with shotCount=3 -> state IDLE, ready=1, counters 0, laserEnable=0 immediately, without waiting for a clock.
- Strobe rate: MOTION_DIV=4, gameEnable=1 for 40 clocks -> exactly 10 laserEnable pulses, spaced 4 clocks apart. Drop gameEnable -> 0 pulses.
- Single shot: press with laserActive=0 -> fire high for 1 cycle, coincident with the next laserEnable. shotCount=1, ready=0.
- Blocked fire: press while laserActive=1 -> no fire until laserActive=0; fire then occurs on the first strobe afterwards.
- Cooldown: after laserActive falls with COOLDOWN_TICKS=2 -> ready returns after the 2nd strobe. A press during cooldown produces no shot.
- Hit count: killingAlien=1 on a strobe in FLIGHT -> hitCount=1. A second pulse after laserActive drops -> hitCount stays 1. With LASER_AUTOFIRE_EN defined, holding the button 3 shot cycles -> shotCount=3; with the macro undefined -> shotCount=1.

Source files
------------

// File: rtl/laser_fire_sequencer_if.sv
`default_nettype none
// ============================================================================
//  Module   : laser_fire_sequencer_if
//  Purpose  : Groups the pad/datapath-facing signals of the laser fire
//             sequencer into one bundle.
//  Ports    : gameEnable, fireButton, laserActive, killingAlien  (to sequencer)
//             laserEnable, fire, ready, shotCount, hitCount       (from sequencer)
//  Modports : slave  - the sequencer itself
//             master - the surrounding top level / stimulus
//  Revision : 1.0  initial release
// ============================================================================
interface laser_fire_sequencer_if #(
    parameter int CNT_W = 8
);
    logic             gameEnable;
    logic             fireButton;
    logic             laserActive;
    logic             killingAlien;
    logic             laserEnable;
    logic             fire;
    logic             ready;
    logic [CNT_W-1:0] shotCount;
    logic [CNT_W-1:0] hitCount;

    modport slave (
        input  gameEnable, fireButton, laserActive, killingAlien,
        output laserEnable, fire, ready, shotCount, hitCount
    );

    modport master (
        output gameEnable, fireButton, laserActive, killingAlien,
        input  laserEnable, fire, ready, shotCount, hitCount
    );
endinterface
`default_nettype wire

// File: rtl/laser_fire_sequencer.sv
`default_nettype none
// ============================================================================
//  Module   : laser_fire_sequencer
//  Purpose  : Generates the laser motion-rate strobe, turns fire-button
//             presses into a one-cycle fire request for a dead laser,
//             enforces a post-shot cooldown and counts shots and hits.
//  Ports    : clk    - system clock
//             reset  - asynchronous, active-high reset
//             bus    - laser_fire_sequencer_if.slave (game/pad/datapath side)
//  Params   : MOTION_DIV     clocks per laserEnable strobe (>= 2)
//             COOLDOWN_TICKS strobes to wait after the laser dies (0 allowed)
//             CNT_W          width of the shot / hit counters
//  Options  : define LASER_AUTOFIRE_EN to let a held button re-arm from IDLE
//  Revision : 1.0  initial release
// ============================================================================
module laser_fire_sequencer #(
    parameter int MOTION_DIV     = 4,
    parameter int COOLDOWN_TICKS = 8,
    parameter int CNT_W          = 8
) (
    input  wire logic               clk,
    input  wire logic               reset,
    laser_fire_sequencer_if.slave   bus
);

    localparam int c_PRE_W = $clog2(MOTION_DIV);
    localparam int c_CD_W  = (COOLDOWN_TICKS > 0) ? $clog2(COOLDOWN_TICKS + 1) : 1;

    localparam logic [c_PRE_W-1:0] c_PRE_MAX = c_PRE_W'(MOTION_DIV - 1);
    localparam logic [c_PRE_W-1:0] c_PRE_ONE = c_PRE_W'(1);
    localparam logic [c_CD_W-1:0]  c_CD_LOAD = c_CD_W'(COOLDOWN_TICKS);
    localparam logic [c_CD_W-1:0]  c_CD_ONE  = c_CD_W'(1);
    localparam logic [CNT_W-1:0]   c_CNT_ONE = CNT_W'(1);

    typedef enum logic [1:0] {
        S_IDLE     = 2'd0,
        S_ARMED    = 2'd1,
        S_FLIGHT   = 2'd2,
        S_COOLDOWN = 2'd3
    } state_t;

    logic [c_PRE_W-1:0] r_presc;
    logic               r_le;
    logic               r_sync1;
    logic               r_sync2;
    logic               r_sync3;
    logic               r_press;

    state_t             r_state;
    state_t             w_state_next;
    logic               r_seen;
    logic               w_seen_next;
    logic [c_CD_W-1:0]  r_cool;
    logic [c_CD_W-1:0]  w_cool_next;
    logic [CNT_W-1:0]   r_shot;
    logic [CNT_W-1:0]   w_shot_next;
    logic [CNT_W-1:0]   r_hit;
    logic [CNT_W-1:0]   w_hit_next;

    logic               w_fire;
    logic               w_arm_req;

    // ------------------------------------------------------------------
    // Prescaler. The strobe is registered, so it appears in the cycle
    // after the count reaches its top value. While the game is paused the
    // count freezes, so the strobe phase resumes where it left off.
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_presc <= '0;
            r_le    <= 1'b0;
        end else if (bus.gameEnable) begin
            r_presc <= (r_presc == c_PRE_MAX) ? '0 : (r_presc + c_PRE_ONE);
            r_le    <= (r_presc == c_PRE_MAX);
        end else begin
            r_le    <= 1'b0;
        end
    end

    // ------------------------------------------------------------------
    // Button path: two-flop synchronizer, a history flop for the edge
    // detector, and a registered press pulse (3 clocks after the rise).
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_sync1 <= 1'b0;
            r_sync2 <= 1'b0;
            r_sync3 <= 1'b0;
            r_press <= 1'b0;
        end else begin
            r_sync1 <= bus.fireButton;
            r_sync2 <= r_sync1;
            r_sync3 <= r_sync2;
            r_press <= r_sync2 & ~r_sync3;
        end
    end

`ifdef LASER_AUTOFIRE_EN
    // A held (synchronized) button re-arms as soon as the gun is ready.
    assign w_arm_req = r_press | r_sync2;
`else
    assign w_arm_req = r_press;
`endif

    // Fire only into a dead laser, and only on a motion strobe.
    assign w_fire = (r_state == S_ARMED) & r_le & ~bus.laserActive;

    // ------------------------------------------------------------------
    // Gun state machine
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= S_IDLE;
            r_seen  <= 1'b0;
            r_cool  <= '0;
            r_shot  <= '0;
            r_hit   <= '0;
        end else begin
            r_state <= w_state_next;
            r_seen  <= w_seen_next;
            r_cool  <= w_cool_next;
            r_shot  <= w_shot_next;
            r_hit   <= w_hit_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        w_seen_next  = r_seen;
        w_cool_next  = r_cool;
        w_shot_next  = r_shot;
        w_hit_next   = r_hit;

        case (r_state)
            S_IDLE: begin
                if (w_arm_req) begin
                    w_state_next = S_ARMED;
                end
            end

            S_ARMED: begin
                if (w_fire) begin
                    w_state_next = S_FLIGHT;
                    w_shot_next  = r_shot + c_CNT_ONE;
                end
            end

            S_FLIGHT: begin
                // The datapath kills the laser on a hit, so this counts
                // at most once per shot.
                if (r_le & bus.killingAlien & bus.laserActive) begin
                    w_hit_next = r_hit + c_CNT_ONE;
                end
                // The laser only goes live one cycle after fire; wait to
                // see it alive before treating "inactive" as "died".
                if (r_seen & ~bus.laserActive) begin
                    w_state_next = S_COOLDOWN;
                    w_cool_next  = c_CD_LOAD;
                    w_seen_next  = 1'b0;
                end else if (bus.laserActive) begin
                    w_seen_next  = 1'b1;
                end
            end

            S_COOLDOWN: begin
                if (r_cool == '0) begin
                    w_state_next = S_IDLE;
                end else if (r_le) begin
                    w_cool_next  = r_cool - c_CD_ONE;
                end
            end

            default: begin
                w_state_next = S_IDLE;
            end
        endcase
    end

    assign bus.laserEnable = r_le;
    assign bus.fire        = w_fire;
    assign bus.ready       = (r_state == S_IDLE);
    assign bus.shotCount   = r_shot;
    assign bus.hitCount    = r_hit;

endmodule
`default_nettype wire
